// File: rtl/lander_pkg.sv
// Shared types, constants and BCD helpers for the lunar lander physics sequencer.
package lander_pkg;

    localparam int BCD_W = 16;

    localparam logic [BCD_W-1:0] ALT_INIT_DEF  = 16'h4500;
    localparam logic [BCD_W-1:0] VEL_INIT_DEF  = 16'h0000;
    localparam logic [BCD_W-1:0] FUEL_INIT_DEF = 16'h0800;
    localparam logic [BCD_W-1:0] GRAVITY_DEF   = 16'h0005;
    localparam logic [BCD_W-1:0] SAFE_VEL_DEF  = 16'h0030;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FUEL   = 3'd1,
        ST_ALT    = 3'd2,
        ST_VEL1   = 3'd3,
        ST_VEL2   = 3'd4,
        ST_COMMIT = 3'd5
    } seq_state_t;

    function automatic logic [3:0] bcd_clamp9(input logic [3:0] x);
        return (x > 4'd9) ? 4'd9 : x;
    endfunction

    // 10's complement of a 4-digit BCD value, used to build the safe-speed threshold.
    function automatic logic [BCD_W-1:0] bcd_tens_comp(input logic [BCD_W-1:0] x);
        logic [BCD_W-1:0] r;
        logic [3:0]       d;
        logic             c;
        r = '0;
        c = 1'b1;
        for (int i = 0; i < BCD_W / 4; i++) begin
            d = 4'd9 - x[i*4 +: 4] + {3'b000, c};
            if (d == 4'd10) begin
                d = 4'd0;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            r[i*4 +: 4] = d;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcdaddsub4.sv
// 4-digit BCD adder/subtractor: op=0 gives a+b+cin, op=1 gives a-b-cin, both mod 10000.
module bcdaddsub4 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        op,
    input  logic        cin,
    output logic [15:0] sum
);

    logic [3:0] bd;
    logic [4:0] s;
    logic       c;

    // Subtraction adds the 9's complement of b with an inverted carry-in.
    always_comb begin
        sum = '0;
        bd  = '0;
        s   = '0;
        c   = op ? ~cin : cin;
        for (int i = 0; i < 4; i++) begin
            bd = op ? (4'd9 - b[i*4 +: 4]) : b[i*4 +: 4];
            s  = {1'b0, a[i*4 +: 4]} + {1'b0, bd} + {4'b0000, c};
            if (s > 5'd9) begin
                s = s + 5'd6;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            sum[i*4 +: 4] = s[3:0];
        end
    end

endmodule

// File: rtl/lander_update_seq.sv
// Per-tick lander physics sequencer: fuel, altitude and velocity updates through one
// shared BCD add/subtract unit, then commit with touchdown classification.
module lander_update_seq
    import lander_pkg::*;
#(
    parameter logic [BCD_W-1:0] ALT_INIT  = ALT_INIT_DEF,
    parameter logic [BCD_W-1:0] VEL_INIT  = VEL_INIT_DEF,
    parameter logic [BCD_W-1:0] FUEL_INIT = FUEL_INIT_DEF,
    parameter logic [BCD_W-1:0] GRAVITY   = GRAVITY_DEF,
    parameter logic [BCD_W-1:0] SAFE_VEL  = SAFE_VEL_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic [3:0]  thrust_in,
    output logic [15:0] alt,
    output logic [15:0] vel,
    output logic [15:0] fuel,
    output logic [3:0]  thrust,
    output logic        busy,
    output logic        done,
    output logic        land,
    output logic        crash
);

    // Downward speeds at or above this 10's-complement value are slow enough to land.
    localparam logic [BCD_W-1:0] VEL_SAFE_MIN = bcd_tens_comp(SAFE_VEL);

    seq_state_t       state_q, state_d;
    logic [BCD_W-1:0] alt_q, alt_d, vel_q, vel_d, fuel_q, fuel_d;
    logic [3:0]       thrust_q, thrust_d;
    logic             done_q, done_d, land_q, land_d, crash_q, crash_d;
    logic             td_q, td_d, ok_q, ok_d;

    logic [BCD_W-1:0] alt_w_q, alt_w_d, vel_w_q, vel_w_d, fuel_w_q, fuel_w_d;
    logic [3:0]       thr_q, thr_d;

    logic [BCD_W-1:0] add_a, add_b, add_sum;
    logic             add_op;
    logic [3:0]       thr_clamped, thr_min;

    bcdaddsub4 u_addsub (
        .a   (add_a),
        .b   (add_b),
        .op  (add_op),
        .cin (1'b0),
        .sum (add_sum)
    );

    always_comb begin
        thr_clamped = bcd_clamp9(thrust_in);
        thr_min     = ({12'h000, thr_clamped} > fuel_q) ? fuel_q[3:0] : thr_clamped;
    end

    always_comb begin
        state_d  = state_q;
        alt_d    = alt_q;
        vel_d    = vel_q;
        fuel_d   = fuel_q;
        thrust_d = thrust_q;
        done_d   = 1'b0;
        land_d   = land_q;
        crash_d  = crash_q;
        td_d     = td_q;
        ok_d     = ok_q;
        alt_w_d  = alt_w_q;
        vel_w_d  = vel_w_q;
        fuel_w_d = fuel_w_q;
        thr_d    = thr_q;
        add_a    = '0;
        add_b    = '0;
        add_op   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (tick && !land_q && !crash_q) begin
                    thr_d    = thr_min;
                    alt_w_d  = alt_q;
                    vel_w_d  = vel_q;
                    fuel_w_d = fuel_q;
                    td_d     = 1'b0;
                    state_d  = ST_FUEL;
                end
            end
            ST_FUEL: begin
                add_a    = fuel_w_q;
                add_b    = {12'h000, thr_q};
                add_op   = 1'b1;
                fuel_w_d = add_sum;
                state_d  = ST_ALT;
            end
            ST_ALT: begin
                add_a   = alt_w_q;
                add_b   = vel_w_q;
                alt_w_d = add_sum;
                // A descending craft whose sum wrapped past zero has reached the ground.
                td_d    = ((vel_w_q[15:12] >= 4'd5) && (add_sum > alt_w_q)) || (add_sum == '0);
                ok_d    = (vel_w_q == '0) || (vel_w_q >= VEL_SAFE_MIN);
                state_d = td_d ? ST_COMMIT : ST_VEL1;
            end
            ST_VEL1: begin
                add_a   = vel_w_q;
                add_b   = {12'h000, thr_q};
                vel_w_d = add_sum;
                state_d = ST_VEL2;
            end
            ST_VEL2: begin
                add_a   = vel_w_q;
                add_b   = GRAVITY;
                add_op  = 1'b1;
                vel_w_d = add_sum;
                state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                if (td_q) begin
                    alt_d   = '0;
                    vel_d   = '0;
                    land_d  = land_q | ok_q;
                    crash_d = crash_q | ~ok_q;
                end else begin
                    alt_d = alt_w_q;
                    vel_d = vel_w_q;
                end
                fuel_d   = fuel_w_q;
                thrust_d = thr_q;
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            alt_q    <= ALT_INIT;
            vel_q    <= VEL_INIT;
            fuel_q   <= FUEL_INIT;
            thrust_q <= 4'd0;
            done_q   <= 1'b0;
            land_q   <= 1'b0;
            crash_q  <= 1'b0;
            td_q     <= 1'b0;
            ok_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            alt_q    <= alt_d;
            vel_q    <= vel_d;
            fuel_q   <= fuel_d;
            thrust_q <= thrust_d;
            done_q   <= done_d;
            land_q   <= land_d;
            crash_q  <= crash_d;
            td_q     <= td_d;
            ok_q     <= ok_d;
        end
    end

    // Working registers are always reloaded on accept, so they need no reset.
    always_ff @(posedge clk) begin
        alt_w_q  <= alt_w_d;
        vel_w_q  <= vel_w_d;
        fuel_w_q <= fuel_w_d;
        thr_q    <= thr_d;
    end

    assign alt    = alt_q;
    assign vel    = vel_q;
    assign fuel   = fuel_q;
    assign thrust = thrust_q;
    assign busy   = (state_q != ST_IDLE);
    assign done   = done_q;
    assign land   = land_q;
    assign crash  = crash_q;

endmodule
